// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32I decode types, encodings and opcode constants
package rv32_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [2:0] {
    BR_EQ = 3'd0, BR_NE = 3'd1, BR_NEVER2 = 3'd2, BR_NEVER3 = 3'd3,
    BR_LT = 3'd4, BR_GE = 3'd5, BR_LTU = 3'd6, BR_GEU = 3'd7
  } branch_type_t;

  localparam logic [2:0] LS_NONE = 3'd0;
  localparam logic [2:0] LS_LB   = 3'd1;
  localparam logic [2:0] LS_LH   = 3'd2;
  localparam logic [2:0] LS_LW   = 3'd3;
  localparam logic [2:0] LS_SB   = 3'd5;
  localparam logic [2:0] LS_SH   = 3'd6;
  localparam logic [2:0] LS_SW   = 3'd7;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0f;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef struct packed {
    logic [4:0]   rs1_addr;
    logic [4:0]   rs2_addr;
    logic [4:0]   rd_addr;
    logic [31:0]  imm;
    alu_op_t      alu_op;
    logic         rs1_pc;
    logic         rs2_imm;
    logic         branch;
    branch_type_t branch_type;
    logic         jump;
    logic [2:0]   loadstore;
    logic         load_zeroextend;
    logic [31:0]  pc;
    logic [32:0]  inst_raw;
  } instruction_t;

  // alt selects SUB/SRA; the caller decides where instr[30] is meaningful
  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32_alu_core.sv
// rtl/rv32_alu_core.sv - registered ALU with optional one-bit-per-cycle shifter
module rv32_alu_core
  import rv32_pkg::*;
#(
  parameter bit USE_BARREL_SHIFTER = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        result_valid
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      state, state_next;
  logic [31:0] result_next, comb_result;
  logic [4:0]  cnt, cnt_next;
  alu_op_t     shift_op, shift_op_next;
  logic        is_shift;

  always_comb begin
    comb_result = '0;
    case (op)
      ALU_ADD:    comb_result = a + b;
      ALU_SUB:    comb_result = a - b;
      ALU_SLL:    comb_result = a << b[4:0];
      ALU_SLT:    comb_result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:   comb_result = {31'b0, a < b};
      ALU_XOR:    comb_result = a ^ b;
      ALU_SRL:    comb_result = a >> b[4:0];
      ALU_SRA:    comb_result = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:     comb_result = a | b;
      ALU_AND:    comb_result = a & b;
      ALU_PASS_B: comb_result = b;
      default:    comb_result = '0;
    endcase
  end

  assign is_shift = (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);

  // The result register doubles as the shift accumulator in serial mode
  always_comb begin
    state_next    = state;
    result_next   = result;
    cnt_next      = cnt;
    shift_op_next = shift_op;
    case (state)
      S_IDLE: begin
        if (valid) begin
          if (!USE_BARREL_SHIFTER && is_shift && (b[4:0] != 5'd0)) begin
            state_next    = S_BUSY;
            result_next   = a;
            cnt_next      = b[4:0];
            shift_op_next = op;
          end else begin
            result_next = comb_result;
          end
        end
      end
      S_BUSY: begin
        case (shift_op)
          ALU_SLL: result_next = {result[30:0], 1'b0};
          ALU_SRA: result_next = {result[31], result[31:1]};
          default: result_next = {1'b0, result[31:1]};
        endcase
        cnt_next = cnt - 5'd1;
        if (cnt == 5'd1) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      result   <= '0;
      cnt      <= '0;
      shift_op <= ALU_ADD;
    end else begin
      state    <= state_next;
      result   <= result_next;
      cnt      <= cnt_next;
      shift_op <= shift_op_next;
    end
  end

  assign result_valid = (state == S_IDLE);

endmodule

// File: rtl/rv32i_exec_unit.sv
// rtl/rv32i_exec_unit.sv - RV32I decode, branch compare and registered ALU stage
module rv32i_exec_unit
  import rv32_pkg::*;
#(
  parameter bit USE_BARREL_SHIFTER = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic        i_valid,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_alu_out,
  output logic        o_alu_valid,
  output logic        o_take_branch,
  output logic        o_take_jump,
  output logic [31:0] o_target,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [2:0]  o_loadstore,
  output logic        o_load_zeroext,
  output logic        o_illegal
);

  instruction_t dec;
  logic [31:0]  ins, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]   opcode, f7;
  logic [2:0]   f3;
  logic         legal, cond;
  logic [31:0]  op_a, op_b, tgt_b, tgt_sum;

  always_comb begin
    dec          = '0;
    dec.inst_raw = {1'b1, i_instr};
    dec.pc       = i_pc;
    ins          = dec.inst_raw[31:0];
    opcode       = ins[6:0];
    f3           = ins[14:12];
    f7           = ins[31:25];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_u = {ins[31:12], 12'b0};
    imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    dec.rs1_addr    = ins[19:15];
    dec.rs2_addr    = ins[24:20];
    dec.rd_addr     = ins[11:7];
    dec.alu_op      = ALU_ADD;
    dec.rs2_imm     = 1'b1;
    dec.branch_type = branch_type_t'(f3);
    legal           = 1'b1;
    case (opcode)
      OP_LUI:   begin dec.imm = imm_u; dec.alu_op = ALU_PASS_B; end
      OP_AUIPC: begin dec.imm = imm_u; dec.rs1_pc = 1'b1; end
      OP_JAL:   begin dec.imm = imm_j; dec.rs1_pc = 1'b1; dec.jump = 1'b1; end
      OP_JALR:  begin dec.imm = imm_i; dec.jump = 1'b1; legal = (f3 == 3'd0); end
      OP_BRANCH: begin
        dec.imm     = imm_b;
        dec.rs1_pc  = 1'b1;
        dec.rs2_imm = 1'b0;
        dec.branch  = 1'b1;
        dec.rd_addr = 5'd0;
      end
      OP_LOAD: begin
        dec.imm             = imm_i;
        dec.loadstore       = {1'b0, f3[1:0] + 2'd1};
        dec.load_zeroextend = f3[2];
        legal = (f3[1:0] != 2'b11) && !(f3[2] && f3[1]);
      end
      OP_STORE: begin
        dec.imm       = imm_s;
        dec.loadstore = {1'b1, f3[1:0] + 2'd1};
        dec.rd_addr   = 5'd0;
        legal = !f3[2] && (f3[1:0] != 2'b11);
      end
      OP_IMM: begin
        dec.imm    = imm_i;
        dec.alu_op = alu_from_f3(f3, (f3 == 3'd5) && ins[30]);
        if (f3 == 3'd1)      legal = (f7 == 7'h00);
        else if (f3 == 3'd5) legal = ((f7 & 7'h5f) == 7'h00);
      end
      OP_REG: begin
        dec.rs2_imm = 1'b0;
        dec.alu_op  = alu_from_f3(f3, ins[30]);
        legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
      end
      OP_FENCE, OP_SYSTEM: dec.rd_addr = 5'd0;
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.rd_addr         = 5'd0;
      dec.branch          = 1'b0;
      dec.jump            = 1'b0;
      dec.loadstore       = LS_NONE;
      dec.load_zeroextend = 1'b0;
      dec.inst_raw[32]    = 1'b0;
    end
  end

  // Comparison works on the forwarded registers, not the ALU operands
  always_comb begin
    cond = 1'b0;
    case (dec.branch_type)
      BR_EQ:   cond = (i_rs1_data == i_rs2_data);
      BR_NE:   cond = (i_rs1_data != i_rs2_data);
      BR_LT:   cond = ($signed(i_rs1_data) < $signed(i_rs2_data));
      BR_GE:   cond = ($signed(i_rs1_data) >= $signed(i_rs2_data));
      BR_LTU:  cond = (i_rs1_data < i_rs2_data);
      BR_GEU:  cond = (i_rs1_data >= i_rs2_data);
      default: cond = 1'b0;
    endcase
  end

  assign op_a    = dec.rs1_pc ? dec.pc : i_rs1_data;
  assign op_b    = dec.rs2_imm ? dec.imm : i_rs2_data;
  assign tgt_b   = dec.branch ? dec.imm : op_b;
  assign tgt_sum = op_a + tgt_b;

  assign o_rs1_addr     = dec.rs1_addr;
  assign o_rs2_addr     = dec.rs2_addr;
  assign o_rd_addr      = dec.rd_addr;
  assign o_take_branch  = dec.branch && cond;
  assign o_take_jump    = dec.jump;
  assign o_target       = {tgt_sum[31:1], 1'b0};
  assign o_mem_addr     = i_rs1_data + dec.imm;
  assign o_mem_wdata    = i_rs2_data;
  assign o_loadstore    = dec.loadstore;
  assign o_load_zeroext = dec.load_zeroextend;
  assign o_illegal      = !dec.inst_raw[32];

  rv32_alu_core #(.USE_BARREL_SHIFTER(USE_BARREL_SHIFTER)) u_alu (
    .clk          (i_clk),
    .rst          (i_rst),
    .valid        (i_valid),
    .op           (dec.alu_op),
    .a            (op_a),
    .b            (op_b),
    .result       (o_alu_out),
    .result_valid (o_alu_valid)
  );

endmodule

// File: tb/tb_rv32i_exec_unit.sv
// tb/tb_rv32i_exec_unit.sv - directed-vector bench for serial and barrel exec units
module tb_rv32i_exec_unit;

  logic        clk = 1'b0;
  logic        rst, valid;
  logic [31:0] instr, pc, rs1, rs2;

  logic [4:0]  b_rs1a, b_rs2a, b_rda, s_rs1a, s_rs2a, s_rda;
  logic [31:0] b_out, b_tgt, b_maddr, b_wdata, s_out, s_tgt, s_maddr, s_wdata;
  logic        b_val, b_br, b_jmp, b_zx, b_ill, s_val, s_br, s_jmp, s_zx, s_ill;
  logic [2:0]  b_ls, s_ls;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv32i_exec_unit #(.USE_BARREL_SHIFTER(1'b1)) u_bar (
    .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_pc(pc),
    .i_rs1_data(rs1), .i_rs2_data(rs2), .i_valid(valid),
    .o_rs1_addr(b_rs1a), .o_rs2_addr(b_rs2a), .o_rd_addr(b_rda),
    .o_alu_out(b_out), .o_alu_valid(b_val), .o_take_branch(b_br),
    .o_take_jump(b_jmp), .o_target(b_tgt), .o_mem_addr(b_maddr),
    .o_mem_wdata(b_wdata), .o_loadstore(b_ls), .o_load_zeroext(b_zx),
    .o_illegal(b_ill)
  );

  rv32i_exec_unit #(.USE_BARREL_SHIFTER(1'b0)) u_ser (
    .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_pc(pc),
    .i_rs1_data(rs1), .i_rs2_data(rs2), .i_valid(valid),
    .o_rs1_addr(s_rs1a), .o_rs2_addr(s_rs2a), .o_rd_addr(s_rda),
    .o_alu_out(s_out), .o_alu_valid(s_val), .o_take_branch(s_br),
    .o_take_jump(s_jmp), .o_target(s_tgt), .o_mem_addr(s_maddr),
    .o_mem_wdata(s_wdata), .o_loadstore(s_ls), .o_load_zeroext(s_zx),
    .o_illegal(s_ill)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; instr = 32'h13; pc = '0; rs1 = '0; rs2 = '0;
    tick(); tick();
    check("reset_bar_out", b_out, 32'h0);
    check("reset_bar_valid", {31'b0, b_val}, 32'h1);
    check("reset_ser_out", s_out, 32'h0);
    check("reset_ser_valid", {31'b0, s_val}, 32'h1);
    rst = 1'b0;

    // ADDI x5,x1,-1
    instr = 32'hFFF08293; rs1 = 32'd5; valid = 1'b1; #1;
    check("addi_rd", {27'b0, b_rda}, 32'd5);
    check("addi_rs1a", {27'b0, b_rs1a}, 32'd1);
    check("addi_illegal", {31'b0, b_ill}, 32'h0);
    tick();
    check("addi_bar_out", b_out, 32'd4);
    check("addi_ser_out", s_out, 32'd4);
    valid = 1'b0; rs1 = 32'd100; tick();
    check("hold_out", b_out, 32'd4);

    // SUB x3,x1,x2 ; LUI x7,0x12345 ; AUIPC x4,1
    instr = 32'h402081B3; rs1 = 32'd5; rs2 = 32'd7; valid = 1'b1; tick();
    check("sub_out", b_out, 32'hFFFFFFFE);
    instr = 32'h123453B7; tick();
    check("lui_out", b_out, 32'h12345000);
    instr = 32'h00001217; pc = 32'h100; tick();
    check("auipc_out", b_out, 32'h00001100);
    valid = 1'b0;

    // BLT / BLTU / BEQ-style f3=2 never taken
    instr = 32'h0020C863; pc = 32'h100; rs1 = 32'hFFFFFFFF; rs2 = 32'd1; #1;
    check("blt_take", {31'b0, b_br}, 32'h1);
    check("blt_target", b_tgt, 32'h110);
    check("blt_rd", {27'b0, b_rda}, 32'h0);
    instr = 32'h0020E863; #1;
    check("bltu_take", {31'b0, b_br}, 32'h0);
    check("bltu_target", b_tgt, 32'h110);
    instr = 32'h0020A863; rs1 = 32'd1; #1;
    check("f3_2_take", {31'b0, b_br}, 32'h0);
    check("f3_2_illegal", {31'b0, b_ill}, 32'h0);

    // JALR x1,0(x5)
    instr = 32'h000280E7; rs1 = 32'h1003; valid = 1'b1; #1;
    check("jalr_jump", {31'b0, b_jmp}, 32'h1);
    check("jalr_target", b_tgt, 32'h1002);
    check("jalr_branch", {31'b0, b_br}, 32'h0);
    tick();
    check("jalr_out", b_out, 32'h1003);
    valid = 1'b0;

    // SW x2,8(x1) ; LHU x3,0(x1)
    instr = 32'h0020A423; rs1 = 32'h20; rs2 = 32'hAB; #1;
    check("sw_ls", {29'b0, b_ls}, 32'd7);
    check("sw_addr", b_maddr, 32'h28);
    check("sw_wdata", b_wdata, 32'hAB);
    check("sw_rd", {27'b0, b_rda}, 32'h0);
    instr = 32'h0000D183; #1;
    check("lhu_ls", {29'b0, b_ls}, 32'd2);
    check("lhu_zx", {31'b0, b_zx}, 32'h1);

    // illegal opcode, then ECALL
    instr = 32'h0000007F; #1;
    check("ill_flag", {31'b0, b_ill}, 32'h1);
    check("ill_rd", {27'b0, b_rda}, 32'h0);
    check("ill_jump", {31'b0, b_jmp}, 32'h0);
    check("ill_branch", {31'b0, b_br}, 32'h0);
    instr = 32'h00000073; #1;
    check("ecall_illegal", {31'b0, b_ill}, 32'h0);

    // SRAI x3,x1,4 on 0x80000000
    instr = 32'h4040D193; rs1 = 32'h80000000; valid = 1'b1; tick();
    valid = 1'b0; rs1 = 32'h0;
    check("srai_bar_out", b_out, 32'hF8000000);
    check("srai_bar_valid", {31'b0, b_val}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("srai_ser_busy", {31'b0, s_val}, 32'h0);
      tick();
    end
    check("srai_ser_valid", {31'b0, s_val}, 32'h1);
    check("srai_ser_out", s_out, 32'hF8000000);

    // SLLI x3,x1,0 is a one-cycle op in serial mode
    instr = 32'h00009193; rs1 = 32'h1234; valid = 1'b1; tick();
    valid = 1'b0;
    check("slli0_ser_valid", {31'b0, s_val}, 32'h1);
    check("slli0_ser_out", s_out, 32'h1234);

    // reset mid-shift
    instr = 32'h4040D193; rs1 = 32'h80000000; valid = 1'b1; tick();
    valid = 1'b0; tick();
    check("pre_rst_busy", {31'b0, s_val}, 32'h0);
    #2; rst = 1'b1; #1;
    check("rst_ser_valid", {31'b0, s_val}, 32'h1);
    check("rst_ser_out", s_out, 32'h0);
    check("rst_bar_out", b_out, 32'h0);
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_exec_unit.md
Name: rv32i_exec_unit

Overview:
Combinational RV32I decoder, branch comparator and ALU with one registered output stage, forming the decode/execute slice of the two-stage pipelined CPU core.
- Decodes the fetched word and reports register addresses to the regfile.
- Takes forwarded rs1/rs2 values and selects the ALU operands.
- Produces a registered ALU result, branch/jump decisions with target address, and load/store controls for the data bus.

Parameters:
USE_BARREL_SHIFTER, 1, 1 = single-cycle shifts; 0 = serial shifter, one bit per cycle.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  reset; asynchronous, active-high.
i_instr  in  32  fetched instruction; the caller substitutes 32'h13 while fetch stalls.
i_pc  in  32  address of i_instr.
i_rs1_data  in  32  forwarded rs1 value.
i_rs2_data  in  32  forwarded rs2 value.
i_valid  in  1  issue strobe; ALU captures its result when high.
o_rs1_addr, o_rs2_addr, o_rd_addr  out  5 each  decoded register addresses; rd = 0 when the instruction has no destination.
o_alu_out  out  32  registered ALU result.
o_alu_valid  out  1  low only while a serial shift is in progress.
o_take_branch  out  1  conditional branch, condition true.
o_take_jump  out  1  JAL or JALR.
o_target  out  32  {(opA+opB)[31:1],1'b0}.
o_mem_addr  out  32  i_rs1_data + imm.
o_mem_wdata  out  32  i_rs2_data.
o_loadstore  out  3  0 none; 1/2/3 load B/H/W; 5/6/7 store B/H/W.
o_load_zeroext  out  1  LBU/LHU.
o_illegal  out  1  unrecognised opcode/funct.

Behaviour:
- Decode is purely combinational.
- Immediates:
  - I: sext[31:20].
  - S: sext{[31:25],[11:7]}.
  - B: sext{[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: sext{[31],[19:12],[20],[30:21],0}.
- Operand A = PC for AUIPC/JAL/branches, else rs1.
- Operand B = imm for every format except R-type and branches, which use rs2.
- Per-opcode actions:
  - LUI: ALU op PASS_B.
  - AUIPC: ADD.
  - JAL: A=PC, B=imm.
  - JALR: A=rs1, B=imm.
  - Branches: A=PC, B=imm for target only; the comparison uses rs1/rs2 directly.
- The branch comparator uses funct3: BEQ, BNE, BLT, BGE (signed), BLTU, BGEU.
  - Funct3 values 2 and 3 never take the branch.
- ALU ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B.
  - SUB and SRA are selected by instr[30], for R-type and shift-immediate only.
  - Shift amount = B[4:0]; SLT/SLTU return 0 or 1.
- Illegal instruction:
  - Decodes as NOP: rd=0, no branch, jump or memory op; o_illegal=1.
  - FENCE and ECALL also decode as NOP, with o_illegal=0.
- ALU register stage:
  - On a rising edge with i_valid=1 and not busy: o_alu_out <= result (one-cycle latency).
  - i_valid=0: o_alu_out holds its value.
- Serial mode (USE_BARREL_SHIFTER=0), when a shift is issued with shamt>0:
  - Enter BUSY and drop o_alu_valid on the next cycle.
  - Shift one bit per cycle; i_valid is ignored while BUSY.
  - After shamt cycles, o_alu_out holds the result, o_alu_valid=1 and the state returns to IDLE.
  - Shift latency is shamt+1 cycles; shamt=0 behaves like a one-cycle op.
- Barrel mode: o_alu_valid is constantly 1.
- Reset (asynchronous): o_alu_out=0, o_alu_valid=1, state IDLE.
  - A reset mid-shift aborts the shift.
- All arithmetic is modulo 2^32; no overflow flags.

Decomposition:
- Package rv32_pkg holds:
  - alu_op_t and branch_type_t enums;
  - loadstore encodings;
  - opcode constants;
  - the instruction_t struct: addresses, imm, alu_op, rs1_pc, rs2_imm, branch, branch_type, jump, loadstore, load_zeroextend, pc, and inst_raw[32:0] with bit 32 = valid.
- Sub-module rv32_alu_core: registered ALU with the optional serial shifter.
- Decode and the branch compare stay inline.

Test Plan:
1. ADDI x5,x1,-1 (0xFFF08293), rs1=5, i_valid=1 → o_rd_addr=5, o_alu_out=4 one cycle later.
2. BLT with rs1=0xFFFFFFFF, rs2=1, PC=0x100, imm=+16 → o_take_branch=1, o_target=0x110. The same values with BLTU → o_take_branch=0.
3. JALR with rs1=0x1003, imm=0 → o_take_jump=1, o_target=0x1002.
4. SRAI by 4 on 0x80000000, USE_BARREL_SHIFTER=0 → o_alu_valid low for 4 cycles, then o_alu_out=0xF8000000. With barrel mode → the same result after 1 cycle.
5. SW x2,8(x1) with rs1=0x20, rs2=0xAB → o_loadstore=7, o_mem_addr=0x28, o_mem_wdata=0xAB, rd=0. LHU → o_loadstore=2, o_load_zeroext=1.
6. Opcode 0x7F → o_illegal=1, rd=0, no jump or branch. Asserting i_rst mid-serial-shift → o_alu_valid=1 and o_alu_out=0 immediately.
